// File: rtl/point_pkg.sv
// ============================================================================
// Module      : point_pkg
// Description : Shared FSM state type, default parameters and reset-position
//               helper for the point_array block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package point_pkg;

    localparam int NUM_PTS_DEF  = 2;
    localparam int COORD_W_DEF  = 5;
    localparam int GRID_MAX_DEF = 11;
    localparam int WRAP_EN_DEF  = 0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_SCAN   = 2'd2,
        S_COMMIT = 2'd3
    } state_e;

    // Point i starts on the diagonal at 3+6*i, pulled in to the grid edge.
    function automatic int init_coord(input int idx, input int grid_max);
        int c;
        c = 3 + 6 * idx;
        return (c > grid_max) ? grid_max : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/point_step.sv
// ============================================================================
// Module      : point_step
// Description : Combinational single-axis step: position plus signed move,
//               then clamp to [0, GRID_MAX] or wrap modulo GRID_MAX+1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module point_step #(
    parameter int COORD_W  = 5,
    parameter int GRID_MAX = 11,
    parameter int WRAP_EN  = 0
) (
    input  logic [COORD_W-1:0] i_cur,
    input  logic [COORD_W-1:0] i_mv,
    output logic [COORD_W-1:0] o_nxt,
    output logic               o_lim
);

    localparam int W = COORD_W + 2;
    localparam logic signed [W-1:0] GMAX_S = W'(GRID_MAX);

    // Two guard bits hold the full unsigned-plus-signed range without overflow.
    logic signed [W-1:0] w_sum;
    assign w_sum = signed'({2'b00, i_cur}) + signed'({{2{i_mv[COORD_W-1]}}, i_mv});

    assign o_lim = (w_sum < 0) || (w_sum > GMAX_S);

    generate
        if (WRAP_EN != 0) begin : g_wrap
            localparam logic signed [W-1:0] MOD_S = W'(GRID_MAX + 1);
            logic signed [W-1:0] w_rem;
            always_comb begin
                w_rem = w_sum % MOD_S;
                o_nxt = (w_rem < 0) ? COORD_W'(w_rem + MOD_S) : COORD_W'(w_rem);
            end
        end else begin : g_clamp
            always_comb begin
                if (w_sum < 0)
                    o_nxt = '0;
                else if (w_sum > GMAX_S)
                    o_nxt = COORD_W'(GRID_MAX);
                else
                    o_nxt = COORD_W'(w_sum);
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/point_array.sv
// ============================================================================
// Module      : point_array
// Description : Array of NUM_PTS grid points; each accepted move is stepped,
//               scanned for collisions one point per cycle, then committed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module point_array
    import point_pkg::*;
#(
    parameter int NUM_PTS  = NUM_PTS_DEF,
    parameter int COORD_W  = COORD_W_DEF,
    parameter int GRID_MAX = GRID_MAX_DEF,
    parameter int WRAP_EN  = WRAP_EN_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mv_valid,
    output logic                       mv_ready,
    input  logic [2:0]                 mv_idx,
    input  logic [COORD_W-1:0]         mv_x,
    input  logic [COORD_W-1:0]         mv_y,
    output logic [NUM_PTS*COORD_W-1:0] pos_x,
    output logic [NUM_PTS*COORD_W-1:0] pos_y,
    output logic                       done,
    output logic [2:0]                 status
);

    state_e                            state_q, state_d;
    logic [2:0]                        idx_q, idx_d;
    logic [COORD_W-1:0]                mvx_q, mvx_d, mvy_q, mvy_d;
    logic [COORD_W-1:0]                tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
    logic [2:0]                        k_q, k_d;
    logic                              edge_q, edge_d;
    logic                              hit_q, hit_d;
    logic                              err_q, err_d;
    logic [NUM_PTS-1:0][COORD_W-1:0]   px_q, px_d, py_q, py_d;
    logic                              done_q, done_d;
    logic [2:0]                        status_q, status_d;

    logic                              w_idx_ok;
    logic [COORD_W-1:0]                w_cur_x, w_cur_y, w_sel_x, w_sel_y;
    logic [COORD_W-1:0]                w_step_x, w_step_y;
    logic                              w_lim_x, w_lim_y;

    assign w_idx_ok = ({1'b0, idx_q} < 4'(NUM_PTS));

    // Out-of-range indices select nothing; their step result is discarded.
    always_comb begin
        w_cur_x = '0;
        w_cur_y = '0;
        w_sel_x = '0;
        w_sel_y = '0;
        for (int i = 0; i < NUM_PTS; i++) begin
            if (idx_q == 3'(i)) begin
                w_cur_x = px_q[i];
                w_cur_y = py_q[i];
            end
            if (k_q == 3'(i)) begin
                w_sel_x = px_q[i];
                w_sel_y = py_q[i];
            end
        end
    end

    point_step #(
        .COORD_W  (COORD_W),
        .GRID_MAX (GRID_MAX),
        .WRAP_EN  (WRAP_EN)
    ) u_step_x (
        .i_cur (w_cur_x),
        .i_mv  (mvx_q),
        .o_nxt (w_step_x),
        .o_lim (w_lim_x)
    );

    point_step #(
        .COORD_W  (COORD_W),
        .GRID_MAX (GRID_MAX),
        .WRAP_EN  (WRAP_EN)
    ) u_step_y (
        .i_cur (w_cur_y),
        .i_mv  (mvy_q),
        .o_nxt (w_step_y),
        .o_lim (w_lim_y)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mvx_d    = mvx_q;
        mvy_d    = mvy_q;
        tgt_x_d  = tgt_x_q;
        tgt_y_d  = tgt_y_q;
        k_d      = k_q;
        edge_d   = edge_q;
        hit_d    = hit_q;
        err_d    = err_q;
        px_d     = px_q;
        py_d     = py_q;
        done_d   = 1'b0;
        status_d = status_q;

        case (state_q)
            S_IDLE: begin
                if (mv_valid) begin
                    idx_d   = mv_idx;
                    mvx_d   = mv_x;
                    mvy_d   = mv_y;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                tgt_x_d = w_step_x;
                tgt_y_d = w_step_y;
                edge_d  = w_idx_ok & (w_lim_x | w_lim_y);
                err_d   = ~w_idx_ok;
                hit_d   = 1'b0;
                k_d     = 3'd0;
                state_d = w_idx_ok ? S_SCAN : S_COMMIT;
            end
            S_SCAN: begin
                // The moving point never collides with its own position.
                if ((k_q != idx_q) && (w_sel_x == tgt_x_q) && (w_sel_y == tgt_y_q))
                    hit_d = 1'b1;
                k_d = k_q + 3'd1;
                if (k_q == 3'(NUM_PTS - 1))
                    state_d = S_COMMIT;
            end
            S_COMMIT: begin
                if (!err_q && !hit_q) begin
                    for (int i = 0; i < NUM_PTS; i++) begin
                        if (idx_q == 3'(i)) begin
                            px_d[i] = tgt_x_q;
                            py_d[i] = tgt_y_q;
                        end
                    end
                end
                done_d   = 1'b1;
                status_d = {err_q, hit_q, edge_q};
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            mvx_q    <= '0;
            mvy_q    <= '0;
            tgt_x_q  <= '0;
            tgt_y_q  <= '0;
            k_q      <= '0;
            edge_q   <= 1'b0;
            hit_q    <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            status_q <= '0;
            for (int i = 0; i < NUM_PTS; i++) begin
                px_q[i] <= COORD_W'(init_coord(i, GRID_MAX));
                py_q[i] <= COORD_W'(init_coord(i, GRID_MAX));
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mvx_q    <= mvx_d;
            mvy_q    <= mvy_d;
            tgt_x_q  <= tgt_x_d;
            tgt_y_q  <= tgt_y_d;
            k_q      <= k_d;
            edge_q   <= edge_d;
            hit_q    <= hit_d;
            err_q    <= err_d;
            done_q   <= done_d;
            status_q <= status_d;
            px_q     <= px_d;
            py_q     <= py_d;
        end
    end

    assign mv_ready = (state_q == S_IDLE);
    assign pos_x    = px_q;
    assign pos_y    = py_q;
    assign done     = done_q;
    assign status   = status_q;

endmodule

`default_nettype wire

// File: tb/tb_point_array.sv
// ============================================================================
// Module      : tb_point_array
// Description : Self-checking bench for point_array; clamp and wrap instances
//               share stimulus and are checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_point_array;

    localparam int NP = 2;
    localparam int CW = 5;
    localparam int GM = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mv_valid = 1'b0;
    logic [2:0]    mv_idx = '0;
    logic [CW-1:0] mv_x = '0;
    logic [CW-1:0] mv_y = '0;

    logic             mv_ready_c, done_c, mv_ready_w, done_w;
    logic [NP*CW-1:0] pos_x_c, pos_y_c, pos_x_w, pos_y_w;
    logic [2:0]       status_c, status_w;

    always #5 clk = ~clk;

    point_array #(.NUM_PTS(NP), .COORD_W(CW), .GRID_MAX(GM), .WRAP_EN(0)) dut_c (
        .clk(clk), .rst(rst), .mv_valid(mv_valid), .mv_ready(mv_ready_c),
        .mv_idx(mv_idx), .mv_x(mv_x), .mv_y(mv_y),
        .pos_x(pos_x_c), .pos_y(pos_y_c), .done(done_c), .status(status_c)
    );

    point_array #(.NUM_PTS(NP), .COORD_W(CW), .GRID_MAX(GM), .WRAP_EN(1)) dut_w (
        .clk(clk), .rst(rst), .mv_valid(mv_valid), .mv_ready(mv_ready_w),
        .mv_idx(mv_idx), .mv_x(mv_x), .mv_y(mv_y),
        .pos_x(pos_x_w), .pos_y(pos_y_w), .done(done_w), .status(status_w)
    );

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int m_x [2][NP];
    int m_y [2][NP];

    always @(posedge clk) if (mv_valid && mv_ready_c) acc_cnt <= acc_cnt + 1;

    typedef struct {
        int idx; int mx; int my; int lat; int st; int x0; int y0; int x1; int y1;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int px(input logic [NP*CW-1:0] v, input int i);
        return int'(v[i*CW +: CW]);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NP; i++) begin
                m_x[d][i] = (3 + 6*i > GM) ? GM : 3 + 6*i;
                m_y[d][i] = m_x[d][i];
            end
    endtask

    task automatic axis(input int cur, input int mv, input bit wrap, output int v, output bit lim);
        int s;
        s = cur + mv;
        lim = (s < 0) || (s > GM);
        if (wrap) v = ((s % (GM+1)) + (GM+1)) % (GM+1);
        else      v = (s < 0) ? 0 : ((s > GM) ? GM : s);
    endtask

    task automatic model_apply(input int d, input int idx, input int mx, input int my, output int st);
        int tx, ty;
        bit lx, ly, coll;
        if (idx >= NP) begin
            st = 4;
            return;
        end
        axis(m_x[d][idx], mx, d == 1, tx, lx);
        axis(m_y[d][idx], my, d == 1, ty, ly);
        coll = 0;
        for (int k = 0; k < NP; k++)
            if (k != idx && m_x[d][k] == tx && m_y[d][k] == ty) coll = 1;
        if (!coll) begin
            m_x[d][idx] = tx;
            m_y[d][idx] = ty;
        end
        st = (coll ? 2 : 0) + ((lx || ly) ? 1 : 0);
    endtask

    task automatic check_pos();
        for (int i = 0; i < NP; i++) begin
            chk("pos_x clamp", px(pos_x_c, i), m_x[0][i]);
            chk("pos_y clamp", px(pos_y_c, i), m_y[0][i]);
            chk("pos_x wrap",  px(pos_x_w, i), m_x[1][i]);
            chk("pos_y wrap",  px(pos_y_w, i), m_y[1][i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        mv_valid = 1'b0;
        rst = 1'b0;
        #2;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // Drives one move, measures done latency on both instances and checks
    // status/positions against the model.
    task automatic run_move(input int idx, input int mx, input int my, input bit hold,
                            output int lat_c, output int st_c);
        int a0, lat_w, st_w, e_c, e_w, e_lat;
        a0 = acc_cnt;
        chk("ready before accept", int'(mv_ready_c), 1);
        mv_valid = 1'b1;
        mv_idx = 3'(idx);
        mv_x = CW'(mx);
        mv_y = CW'(my);
        @(posedge clk); #1;
        if (!hold) begin
            mv_valid = 1'b0;
            mv_idx = 3'($urandom);
            mv_x = CW'($urandom);
            mv_y = CW'($urandom);
        end
        lat_c = 0; lat_w = 0; st_c = -1; st_w = -1;
        for (int cyc = 1; cyc <= 12 && (lat_c == 0 || lat_w == 0); cyc++) begin
            @(posedge clk); #1;
            if (done_c && lat_c == 0) begin lat_c = cyc; st_c = int'(status_c); end
            if (done_w && lat_w == 0) begin lat_w = cyc; st_w = int'(status_w); end
        end
        mv_valid = 1'b0;
        chk("accept count", acc_cnt - a0, 1);
        model_apply(0, idx, mx, my, e_c);
        model_apply(1, idx, mx, my, e_w);
        e_lat = (idx >= NP) ? 2 : NP + 2;
        chk("latency clamp", lat_c, e_lat);
        chk("latency wrap",  lat_w, e_lat);
        chk("status clamp",  st_c, e_c);
        chk("status wrap",   st_w, e_w);
        check_pos();
        @(posedge clk); #1;
        chk("done single pulse clamp", int'(done_c), 0);
        chk("done single pulse wrap",  int'(done_w), 0);
    endtask

    initial begin
        int lat, st, dn;

        tbl[0] = '{0,   6,  6, 4, 2,  3,  3, 9,  9};
        tbl[1] = '{0,   0,  0, 4, 0,  3,  3, 9,  9};
        tbl[2] = '{1,  -2, -2, 4, 0,  3,  3, 7,  7};
        tbl[3] = '{0,  10,  2, 4, 1, 11,  5, 7,  7};
        tbl[4] = '{5,   1,  1, 2, 4, 11,  5, 7,  7};
        tbl[5] = '{1,   4, -2, 4, 2, 11,  5, 7,  7};
        tbl[6] = '{1, -16, 15, 4, 1, 11,  5, 0, 11};
        tbl[7] = '{0, -11,  6, 4, 2, 11,  5, 0, 11};
        tbl[8] = '{2,   0,  0, 2, 4, 11,  5, 0, 11};

        do_reset();
        chk("reset x0", px(pos_x_c, 0), 3);
        chk("reset y0", px(pos_y_c, 0), 3);
        chk("reset x1", px(pos_x_c, 1), 9);
        chk("reset y1", px(pos_y_c, 1), 9);
        chk("reset ready", int'(mv_ready_c), 1);
        chk("reset done", int'(done_c), 0);
        chk("reset status", int'(status_c), 0);
        check_pos();

        // Wrap instance: (3,3) + (-5,+10) lands on (10,1).
        run_move(0, -5, 10, 1'b0, lat, st);
        chk("wrap x0", px(pos_x_w, 0), 10);
        chk("wrap y0", px(pos_y_w, 0), 1);
        chk("wrap status", int'(status_w), 1);

        do_reset();
        for (int t = 0; t < 9; t++) begin
            run_move(tbl[t].idx, tbl[t].mx, tbl[t].my, 1'b0, lat, st);
            chk("tbl latency", lat, tbl[t].lat);
            chk("tbl status", st, tbl[t].st);
            chk("tbl x0", px(pos_x_c, 0), tbl[t].x0);
            chk("tbl y0", px(pos_y_c, 0), tbl[t].y0);
            chk("tbl x1", px(pos_x_c, 1), tbl[t].x1);
            chk("tbl y1", px(pos_y_c, 1), tbl[t].y1);
        end

        // mv_valid held through the busy period of an invalid-index move.
        run_move(5, 3, 3, 1'b1, lat, st);
        chk("hold latency", lat, 2);
        chk("hold status", st, 4);

        // Reset during SCAN aborts the move.
        do_reset();
        mv_valid = 1'b1; mv_idx = 3'd1; mv_x = CW'(-2); mv_y = CW'(-2);
        @(posedge clk); #1;
        mv_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst ready", int'(mv_ready_c), 1);
        chk("midrst done", int'(done_c), 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        dn = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done_c || done_w) dn++;
        end
        chk("midrst no done", dn, 0);
        check_pos();

        for (int r = 0; r < 40; r++) begin
            run_move($urandom_range(0, 3), int'($urandom_range(0, 31)) - 16,
                     int'($urandom_range(0, 31)) - 16, 1'($urandom_range(0, 1)), lat, st);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/point_array.md
POINT_ARRAY -- requirements
Module: point_array

Interface
REQ-001 SHALL have parameter NUM_PTS, default 2, number of tracked points (1..8).
REQ-002 SHALL have parameter COORD_W, default 5, coordinate and move width in bits.
REQ-003 SHALL have parameter GRID_MAX, default 11, maximum legal coordinate; the minimum is 0.
REQ-004 SHALL have parameter WRAP_EN, default 0; 0 selects clamp at the edges, 1 selects modulo (GRID_MAX+1) wrap.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port mv_valid, input, 1, move request valid.
REQ-008 SHALL have port mv_ready, output, 1, block idle and accepting.
REQ-009 SHALL have port mv_idx, input, 3, index of the target point.
REQ-010 SHALL have ports mv_x and mv_y, input, COORD_W each, two's-complement signed moves.
REQ-011 SHALL have ports pos_x and pos_y, output, NUM_PTS*COORD_W each; point i occupies bits [i*COORD_W +: COORD_W].
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port status, output, 3, {err, collide, edge}, valid while done=1 and held until the next done.

Function
REQ-014 SHALL accept a move on a rising edge where mv_valid=1 and mv_ready=1, and SHALL register mv_idx, mv_x and mv_y at that edge.
REQ-015 SHALL use states IDLE -> CALC -> SCAN -> COMMIT -> IDLE; mv_ready=1 only in IDLE.
REQ-016 In CALC, SHALL compute the target = current position + sign-extended move per axis, with COORD_W+2-bit intermediates and no overflow.
REQ-017 With WRAP_EN=0, an axis target <0 SHALL become 0 and a target >GRID_MAX SHALL become GRID_MAX; edge=1 if either axis was limited.
REQ-018 With WRAP_EN=1, an axis target SHALL be reduced modulo (GRID_MAX+1) into 0..GRID_MAX; edge=1 if either axis wrapped.
REQ-019 SCAN SHALL last exactly NUM_PTS cycles, comparing the target against point k (k=0..NUM_PTS-1) in one cycle each and skipping k=mv_idx.
REQ-020 If the target equals any other point's position, the move SHALL be rejected: positions unchanged, collide=1.
REQ-021 In COMMIT, a non-rejected move SHALL update only point mv_idx; done=1 and status SHALL be registered in the same edge, and the state SHALL return to IDLE.
REQ-022 Latency from the accept edge to the edge raising done SHALL be NUM_PTS+2 clocks.
REQ-023 If mv_idx>=NUM_PTS, the block SHALL go CALC -> COMMIT directly with err=1 and no position change (latency 2).
REQ-024 A zero move SHALL complete normally (edge=0); a collision check against the point's own position SHALL never occur.
REQ-025 mv_valid asserted outside IDLE SHALL be ignored; mv_* SHALL not need to be held after the accept edge.

Reset
REQ-026 On rst=0, asynchronously: state=IDLE, done=0, status=0, mv_ready=1 after reset release, and point i set to x=y=min(3+6*i, GRID_MAX).
REQ-027 Reset mid-operation SHALL abort the move with no position update and no done pulse.

Structure
REQ-028 SHALL place the state enum and the default parameter values in shared package point_pkg.
REQ-029 SHALL use one sub-module, point_step, a combinational single-axis add/clamp/wrap unit instantiated twice (x and y).

Verification (NUM_PTS=2, COORD_W=5, GRID_MAX=11)
REQ-030 Reset: pulse rst low -> positions (3,3),(9,9), mv_ready=1, done=0.
REQ-031 idx0 move (+10,+2), WRAP_EN=0 -> point0=(11,5), status=001, done exactly 4 clocks after accept.
REQ-032 idx0 move (+6,+6) from (3,3) -> target (9,9) collides with point1 -> point0 stays (3,3), status=010.
REQ-033 WRAP_EN=1, idx0 move (-5,+10) from (3,3) -> point0=(10,1), status=001.
REQ-034 mv_idx=5 -> no change, status=100, done 2 clocks after accept; mv_valid held high during busy -> exactly one accept.
REQ-035 idx1 move (-2,-2) accepted, rst=0 during SCAN -> positions (3,3),(9,9), no done pulse.
